aes_serial_scheduler: RTL and testbench
=======================================

Name: aes_serial_scheduler

Overview:
- Shares one serial AES core (Encrypt or Decrypt, cs/miso/mosi/finished interface) between two requesters.
- Round-robin arbitration between the requesters.
- Each job runs as: serialise text+key into the core, wait for finished, deserialise the 128-bit result, return it tagged with the requester id.
- Sits between system-side request logic and the core instance.

Parameters:
- Nk, 4, key length in 32-bit words; LOAD_LEN = 128 + 32*Nk bits.
- TIMEOUT, 1024, maximum cycles in WAIT for finished before an error response.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 job valid.
- req0_ready  out  1  requester 0 accept.
- req0_text  in  128  requester 0 text block.
- req0_key  in  32*Nk  requester 0 key.
- req1_valid, req1_ready, req1_text, req1_key  same as requester 0, for requester 1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  128  result block.
- rsp_err  out  1  job timed out.
- busy  out  1  high whenever state != IDLE.
- cs  out  1  core chip select.
- miso  out  1  serial bit into core.
- mosi  in  1  serial bit from core.
- finished  in  1  core done flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; cs=0, miso=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0; counters=0; round-robin pointer set so req0 wins the first tie. Reset mid-job aborts with no response.
- States: IDLE -> LOAD -> WAIT -> READ -> RESP -> IDLE; WAIT -> RESP on timeout.
- IDLE:
  - reqN_ready is combinational: 1 only in IDLE, and only for the arbitration winner.
  - Only one requester is selected; if only one is valid, it wins.
  - If both are valid, the one not granted last wins.
  - On valid&&ready at posedge: latch text/key into a shift register, latch id, update pointer, go to LOAD.
- LOAD:
  - cs=1 for exactly LOAD_LEN cycles.
  - In LOAD cycle k (0-based), miso = text[k] for k<128, else key[k-128]. LSB first, driven from registers.
  - finished is ignored in LOAD.
  - After cycle LOAD_LEN-1, go to WAIT.
- WAIT:
  - cs=0, miso=0.
  - Timeout counter starts at 0 on entry and increments every cycle.
  - finished=1 sampled: go to READ.
  - Else, counter == TIMEOUT-1: go to RESP with rsp_err=1, rsp_data=0.
  - finished=1 on the timeout cycle: finished wins.
- READ:
  - cs=1 for exactly 128 cycles.
  - At the posedge ending READ cycle k, rsp_data[k] <= mosi (LSB first).
  - Then go to RESP with rsp_err=0.
- RESP:
  - cs=0; rsp_valid=1.
  - rsp_id, rsp_data and rsp_err stay stable until rsp_valid&&rsp_ready, then go to IDLE.
  - The next request is accepted no earlier than the cycle after the response handshake; no overlap of jobs.
- Bit counter: 9 bits, wide enough for LOAD_LEN ≤ 384. Cleared on every state entry. Never wraps within a state.
- Requester inputs are sampled only at the accept edge; later changes are ignored.
- busy = (state != IDLE).

Test Plan:
- FIPS-197 vector with Nk=4, using an Encrypt core or a behavioural core model.
  - Stimulus: req0 text 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: cs high exactly 256 cycles; miso stream equals the text bits then the key bits, LSB first; rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_err=0.
- Arbitration:
  - Stimulus: req0_valid and req1_valid both high from the first cycle after reset.
  - Required: req0 accepted first, req1 second; responses rsp_id 0 then 1. A third back-to-back req0+req1 tie grants req0.
- Timeout:
  - Stimulus: TIMEOUT=16; core model never asserts finished.
  - Required: exactly 16 cycles in WAIT; then rsp_valid=1, rsp_err=1, rsp_data=0; no READ phase (cs stays 0).
- Backpressure:
  - Stimulus: rsp_ready held low 10 cycles after rsp_valid rises, with req1_valid high throughout.
  - Required: rsp_* stable over those cycles; req1_ready=0 until the cycle after the handshake.
- Reset mid-LOAD:
  - Stimulus: rst pulled low at LOAD bit 100.
  - Required: cs, miso and rsp_valid drop to 0 immediately (asynchronously); busy=0. After rst rises, a fresh req1 job completes correctly.
- Spurious finished:
  - Stimulus: finished pulsed during LOAD.
  - Required: ignored; LOAD still lasts 256 cycles. A later finished in WAIT advances to READ.

Source files
------------

// File: rtl/aes_serial_scheduler.sv
// ---------------------------------------------------------------------------
// aes_serial_scheduler
//
// Shares one bit-serial AES core between two requesters. Each job is granted
// round-robin, then the 128-bit text and the key are shifted into the core
// LSB first with cs high. The scheduler waits for the core's finished flag,
// shifts the 128-bit result back out of the core, and presents it tagged with
// the requester id. If finished never arrives within TIMEOUT cycles, the job
// completes with an error response and zero data.
//
// Parameters:
//   Nk       key length in 32-bit words; LOAD_LEN = 128 + 32*Nk. Nk up to 8
//            keeps LOAD_LEN within the reach of the 9-bit bit counter.
//   TIMEOUT  maximum number of cycles spent waiting for finished.
//
// Ports:
//   clk, rst             clock (posedge) and asynchronous active-low reset
//   req0_valid/ready     requester 0 handshake; ready only in IDLE, winner only
//   req0_text, req0_key  requester 0 job payload, sampled at the accept edge
//   req1_*               same for requester 1
//   rsp_valid/ready      result handshake
//   rsp_id               requester that owns the result
//   rsp_data             128-bit result block (zero on timeout)
//   rsp_err              job timed out
//   busy                 scheduler is not idle
//   cs, miso             chip select and serial data towards the core
//   mosi, finished       serial data and done flag from the core
// ---------------------------------------------------------------------------
module aes_serial_scheduler #(
  parameter int Nk      = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [127:0]      req0_text,
  input  logic [32*Nk-1:0]  req0_key,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [127:0]      req1_text,
  input  logic [32*Nk-1:0]  req1_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [127:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              cs,
  output logic              miso,
  input  logic              mosi,
  input  logic              finished
);

  localparam int KEY_W    = 32 * Nk;
  localparam int LOAD_LEN = 128 + KEY_W;
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [8:0]    LOAD_LAST = 9'(LOAD_LEN - 1);
  localparam logic [8:0]    READ_LAST = 9'd127;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    READ,
    RESP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [LOAD_LEN-1:0] shift_q;
  logic [8:0]          bit_cnt;
  logic [TW-1:0]       tmo_cnt;
  // Requester granted most recently; reset to 1 so requester 0 wins the
  // first tie.
  logic                last_grant;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, arbitration and the core-facing strobes. All outputs
  // decode straight from registered state, so reset clears them at once.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cs         = 1'b0;
    miso       = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          req0_ready = last_grant;
          req1_ready = !last_grant;
        end else begin
          req0_ready = req0_valid;
          req1_ready = req1_valid;
        end
        if (req0_ready || req1_ready) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        cs   = 1'b1;
        miso = shift_q[0];
        if (bit_cnt == LOAD_LAST) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A finished seen on the last allowed cycle still counts as success.
        if (finished) begin
          state_next = READ;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = RESP;
        end
      end
      READ: begin
        cs = 1'b1;
        if (bit_cnt == READ_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, payload shift register and the response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // The bit counter restarts on every state entry, so LOAD and READ each
      // count from zero.
      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (state == LOAD || state == READ) begin
        bit_cnt <= bit_cnt + 9'd1;
      end

      if (state == WAIT && state_next == WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (req1_ready) begin
            shift_q    <= {req1_key, req1_text};
            rsp_id     <= 1'b1;
            last_grant <= 1'b1;
          end else if (req0_ready) begin
            shift_q    <= {req0_key, req0_text};
            rsp_id     <= 1'b0;
            last_grant <= 1'b0;
          end
        end
        LOAD: begin
          // Text sits in the low bits and the key above it, so shifting
          // right presents text LSB first followed by the key.
          shift_q <= {1'b0, shift_q[LOAD_LEN-1:1]};
        end
        WAIT: begin
          if (finished) begin
            rsp_err <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        end
        READ: begin
          // Shift in at the top: after 128 cycles the bit from READ cycle k
          // lands in position k.
          rsp_data <= {mosi, rsp_data[127:1]};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_serial_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_serial_scheduler
//
// Self-checking bench for aes_serial_scheduler with a behavioural serial
// core. The core model captures the load stream, answers with the FIPS-197
// ciphertext for the FIPS vector and with text^key otherwise, and can be told
// to never finish or to pulse finished during the load. Expected responses
// and load streams are queued when a job is issued; the monitor and the core
// model pop and compare them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_aes_serial_scheduler;

  localparam int NK       = 4;
  localparam int KW       = 32 * NK;
  localparam int LOAD_LEN = 128 + KW;
  localparam int TMO      = 16;

  localparam logic [127:0] FIPS_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [KW-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // Tie test: grants alternate 0,1,0 and then requester 1 alone.
  localparam bit [3:0] TIE_IDS = 4'b1010;
  localparam logic [127:0] TIE_TEXT [4] = '{
    128'h11111111111111111111111111111111,
    128'h0123456789abcdef0123456789abcdef,
    128'hdeadbeef00000000cafef00d12345678,
    128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa};
  localparam logic [KW-1:0] TIE_KEY [4] = '{
    128'h22222222222222222222222222222222,
    128'hffffffffffffffff0000000000000000,
    128'h00000000ffffffff0000000000000000,
    128'h55555555555555555555555555555555};
  localparam logic [127:0] TIE_EXP [4] = '{
    128'h33333333333333333333333333333333,
    128'hfedcba98765432100123456789abcdef,
    128'hdeadbeefffffffffcafef00d12345678,
    128'hffffffffffffffffffffffffffffffff};

  typedef struct packed {
    logic         id;
    logic [127:0] data;
    logic         err;
  } rsp_t;

  typedef enum {M_IDLE, M_LOAD, M_CALC, M_DONE, M_READ} mph_t;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_text, req1_text;
  logic [KW-1:0] req0_key, req1_key;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data;
  logic busy, cs, miso, mosi, finished;

  int compared = 0;
  int mismatched = 0;

  rsp_t exp_q[$];
  logic [LOAD_LEN-1:0] load_q[$];

  // Core model state and knobs.
  mph_t mph = M_IDLE;
  int ld_idx = 0, rd_idx = 0, calc_cnt = 0;
  int run_len = 0, cs_runs = 0, wait_cnt = 0;
  bit run_is_load = 1'b0, prev_cs = 1'b0;
  bit never_finish = 1'b0;
  int spurious_at = -1;
  logic [LOAD_LEN-1:0] ld_bits, exp_ld;
  logic [127:0] result;

  // Monitor state.
  bit held_valid = 1'b0;
  logic held_id, held_err;
  logic [127:0] held_data;

  always #5 clk = ~clk;

  aes_serial_scheduler #(.Nk(NK), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_text(req0_text), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_text(req1_text), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .cs(cs), .miso(miso), .mosi(mosi), .finished(finished));

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: expected event did not happen", name);
  endtask

  // Queues the expected response and load stream, then offers the job until
  // the DUT accepts it. The payload is scrambled afterwards so any late
  // sampling shows up as wrong data.
  task automatic applyStimulus(input bit id, input logic [127:0] text,
                               input logic [KW-1:0] key,
                               input logic [127:0] exp_data, input bit exp_err);
    rsp_t e;
    int n;
    e.id = id; e.data = exp_data; e.err = exp_err;
    exp_q.push_back(e);
    load_q.push_back({key, text});
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_text = text; req1_key = key; end
    else    begin req0_valid = 1'b1; req0_text = text; req0_key = key; end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(id ? req1_ready : req0_ready) && n < 3000);
    if (!(id ? req1_ready : req0_ready)) reportFail("accept_timeout");
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b0; req1_text = ~text; req1_key = ~key; end
    else    begin req0_valid = 1'b0; req0_text = ~text; req0_key = ~key; end
  endtask

  // Both requesters valid back to back; checks who is granted at each step.
  task automatic applyTie();
    rsp_t e;
    int n;
    for (int i = 0; i < 4; i++) begin
      e.id = TIE_IDS[i]; e.data = TIE_EXP[i]; e.err = 1'b0;
      exp_q.push_back(e);
      load_q.push_back({TIE_KEY[i], TIE_TEXT[i]});
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_text = TIE_TEXT[0]; req0_key = TIE_KEY[0];
    req1_valid = 1'b1; req1_text = TIE_TEXT[1]; req1_key = TIE_KEY[1];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(req0_ready || req1_ready) && n < 3000);
      checkOutput("tie_req0_ready", 256'(req0_ready), 256'(TIE_IDS[i] == 1'b0));
      checkOutput("tie_req1_ready", 256'(req1_ready), 256'(TIE_IDS[i] == 1'b1));
      @(posedge clk); #1;
      if (TIE_IDS[i] == 1'b0) begin
        if (i + 2 < 4) begin req0_text = TIE_TEXT[i+2]; req0_key = TIE_KEY[i+2]; end
        else req0_valid = 1'b0;
      end else begin
        if (i + 2 < 4) begin req1_text = TIE_TEXT[i+2]; req1_key = TIE_KEY[i+2]; end
        else req1_valid = 1'b0;
      end
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0 || busy) reportFail("idle_timeout");
    @(negedge clk);
  endtask

  // Behavioural serial core plus cs run-length and WAIT-cycle bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      mph = M_IDLE; ld_idx = 0; rd_idx = 0; calc_cnt = 0;
      finished = 1'b0; mosi = 1'b0; prev_cs = 1'b0; run_len = 0;
    end else begin
      if (cs && !prev_cs) begin
        run_is_load = (mph == M_IDLE);
        if (run_is_load) begin cs_runs = 0; wait_cnt = 0; end
        cs_runs++;
        run_len = 0;
      end
      if (cs) run_len++;
      if (!cs && prev_cs) begin
        if (run_is_load) checkOutput("cs_load_len", 256'(run_len), 256'(LOAD_LEN));
        else             checkOutput("cs_read_len", 256'(run_len), 256'(128));
      end
      prev_cs = cs;
      if (busy && !cs && !rsp_valid) wait_cnt++;
      case (mph)
        M_IDLE, M_LOAD: begin
          if (cs) begin
            mph = M_LOAD;
            ld_bits[ld_idx] = miso;
            finished = (ld_idx == spurious_at);
            ld_idx++;
            if (ld_idx == LOAD_LEN) begin
              finished = 1'b0;
              mph = M_CALC;
              calc_cnt = 0;
              if (ld_bits == {FIPS_KEY, FIPS_TEXT}) result = FIPS_CT;
              else result = ld_bits[127:0] ^ ld_bits[255:128];
              if (load_q.size() == 0) reportFail("load_unexpected");
              else begin
                exp_ld = load_q.pop_front();
                checkOutput("load_stream", ld_bits, exp_ld);
              end
            end
          end
        end
        M_CALC: begin
          if (!never_finish) begin
            calc_cnt++;
            if (calc_cnt == 4) begin finished = 1'b1; mph = M_DONE; end
          end
        end
        M_DONE: begin
          if (cs) begin finished = 1'b0; mosi = result[0]; rd_idx = 1; mph = M_READ; end
        end
        M_READ: begin
          mosi = (cs && rd_idx < 128) ? result[rd_idx] : 1'b0;
          if (cs) rd_idx++;
        end
        default: begin end
      endcase
      if (rsp_valid) begin
        mph = M_IDLE; ld_idx = 0; finished = 1'b0; mosi = 1'b0;
      end
    end
  end

  // Response monitor: holds values stable while stalled and pops the
  // scoreboard on each handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      held_valid = 1'b0;
    end else if (rsp_valid) begin
      if (held_valid)
        checkOutput("rsp_stable", 256'({rsp_id, rsp_err, rsp_data}),
                    256'({held_id, held_err, held_data}));
      held_id = rsp_id; held_err = rsp_err; held_data = rsp_data;
      held_valid = 1'b1;
      if (rsp_ready) begin
        held_valid = 1'b0;
        if (exp_q.size() == 0) reportFail("rsp_unexpected");
        else begin
          e = exp_q.pop_front();
          checkOutput("rsp_id", 256'(rsp_id), 256'(e.id));
          checkOutput("rsp_data", 256'(rsp_data), 256'(e.data));
          checkOutput("rsp_err", 256'(rsp_err), 256'(e.err));
        end
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rsp_t e;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_text = '0; req0_key = '0; req1_text = '0; req1_key = '0;
    #12;
    checkOutput("reset_cs", 256'(cs), 256'(0));
    checkOutput("reset_miso", 256'(miso), 256'(0));
    checkOutput("reset_rsp_valid", 256'(rsp_valid), 256'(0));
    checkOutput("reset_rsp_err", 256'(rsp_err), 256'(0));
    checkOutput("reset_rsp_id", 256'(rsp_id), 256'(0));
    checkOutput("reset_rsp_data", 256'(rsp_data), 256'(0));
    checkOutput("reset_busy", 256'(busy), 256'(0));
    @(posedge clk); #1 rst = 1'b1;

    $display("[TB] arbitration ties");
    applyTie();
    waitIdle();

    $display("[TB] FIPS-197 vector");
    applyStimulus(1'b0, FIPS_TEXT, FIPS_KEY, FIPS_CT, 1'b0);
    waitIdle();
    checkOutput("fips_cs_runs", 256'(cs_runs), 256'(2));

    $display("[TB] spurious finished during load");
    spurious_at = 50;
    applyStimulus(1'b1, 128'h000000000000000000000000000000ff,
                  128'h00000000000000000000000000000f00,
                  128'h00000000000000000000000000000fff, 1'b0);
    waitIdle();
    spurious_at = -1;
    checkOutput("spurious_cs_runs", 256'(cs_runs), 256'(2));

    $display("[TB] timeout");
    never_finish = 1'b1;
    applyStimulus(1'b0, 128'h0badc0de0badc0de0badc0de0badc0de,
                  128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 128'h0, 1'b1);
    waitIdle();
    never_finish = 1'b0;
    checkOutput("timeout_wait_cycles", 256'(wait_cnt), 256'(TMO));
    checkOutput("timeout_cs_runs", 256'(cs_runs), 256'(1));

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 128'h80000000000000000000000000000001,
                  128'h00000000000000000000000000000003,
                  128'h80000000000000000000000000000002, 1'b0);
    e.id = 1'b1; e.data = 128'h00ffff0000ffff0000ffff0000ffff00; e.err = 1'b0;
    exp_q.push_back(e);
    load_q.push_back({128'h00ff00ff00ff00ff00ff00ff00ff00ff,
                      128'h0000ffff0000ffff0000ffff0000ffff});
    req1_text = 128'h0000ffff0000ffff0000ffff0000ffff;
    req1_key  = 128'h00ff00ff00ff00ff00ff00ff00ff00ff;
    req1_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    if (!rsp_valid) reportFail("bp_rsp_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_req1_ready_stall", 256'(req1_ready), 256'(0));
      checkOutput("bp_rsp_valid_stall", 256'(rsp_valid), 256'(1));
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_req1_ready_handshake", 256'(req1_ready), 256'(0));
    @(negedge clk);
    checkOutput("bp_req1_ready_after", 256'(req1_ready), 256'(1));
    @(posedge clk); #1 req1_valid = 1'b0; req1_text = '1; req1_key = '1;
    waitIdle();

    $display("[TB] reset during load");
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_text = 128'hcccccccccccccccccccccccccccccccc;
    req0_key = 128'h33333333333333333333333333333333;
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 100);
    if (!req0_ready) reportFail("abort_accept_timeout");
    @(posedge clk); #1 req0_valid = 1'b0;
    n = 0;
    while (ld_idx != 101 && n < 1000) begin @(negedge clk); #1; n++; end
    if (ld_idx != 101) reportFail("abort_bit100_timeout");
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_cs", 256'(cs), 256'(0));
    checkOutput("abort_miso", 256'(miso), 256'(0));
    checkOutput("abort_rsp_valid", 256'(rsp_valid), 256'(0));
    checkOutput("abort_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    applyStimulus(1'b1, 128'hfedcba9876543210fedcba9876543210, 128'h0,
                  128'hfedcba9876543210fedcba9876543210, 1'b0);
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
